// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU op codes, FSM states.
// Imported by the accumulator ALU and its Booth multiplier core.
package cpu_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_MPY  = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier, one step per cycle.
// Ports: start_i/abort_i, mcand_i/mplier_i, busy_o, done_o, prod_o.
module booth_mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MUL_ITER = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(MUL_ITER + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // High half carries one guard bit so that subtracting the
  // most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     a_sum;
  logic [2*WIDTH+1:0] vec;
  logic [2*WIDTH+1:0] sh;
  logic               last;

  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    unique case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_ext;
      2'b10:   a_sum = a_q - m_ext;
      default: a_sum = a_q;
    endcase
    vec = {a_sum, q_q, qm1_q};
    sh  = {vec[2*WIDTH+1], vec[2*WIDTH+1:1]};
  end

  assign last   = (cnt_q == CW'(MUL_ITER - 1));
  assign busy_o = (state_q == ST_MUL);
  assign done_o = busy_o && !abort_i && last;
  assign prod_o = sh[2*WIDTH:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_MUL;
          cnt_d   = '0;
          a_d     = '0;
          q_d     = mplier_i;
          qm1_d   = 1'b0;
          m_d     = mcand_i;
        end
      end
      ST_MUL: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          a_d   = sh[2*WIDTH+1:WIDTH+1];
          q_d   = sh[WIDTH:1];
          qm1_d = sh[0];
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
    end
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle ops on ACC plus Booth MPY into {MR,ACC}.
// Ports: br_data/alu_start/alu_op/acc_clear in; acc/mr/busy/done/flags out.
module acc_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] br_data,
  input  logic             alu_start,
  input  logic [3:0]       alu_op,
  input  logic             acc_clear,
  output logic [WIDTH-1:0] acc_data,
  output logic [WIDTH-1:0] mr_data,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             nf,
  output logic             of
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             of_q, of_d;
  logic             done_q, done_d;

  logic               mul_busy;
  logic               mul_done;
  logic               mul_go;
  logic               op_go;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0] sum, diff, res;
  logic             ovf, upd;

  assign mul_go = alu_start && !acc_clear && !mul_busy
                  && (alu_op == OP_MPY);
  assign op_go  = alu_start && !acc_clear && !mul_busy
                  && (alu_op != OP_MPY);

  booth_mul_seq #(
    .WIDTH    (WIDTH),
    .MUL_ITER (MUL_ITER)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_go),
    .abort_i  (acc_clear),
    .mcand_i  (br_data),
    .mplier_i (acc_q),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .prod_o   (prod)
  );

  always_comb begin
    sum  = acc_q + br_data;
    diff = acc_q - br_data;
    res  = acc_q;
    ovf  = 1'b0;
    upd  = 1'b1;
    unique case (1'b1)
      alu_op == OP_ADD: begin
        res = sum;
        ovf = (acc_q[WIDTH-1] == br_data[WIDTH-1])
              && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      alu_op == OP_SUB: begin
        res = diff;
        ovf = (acc_q[WIDTH-1] != br_data[WIDTH-1])
              && (diff[WIDTH-1] != acc_q[WIDTH-1]);
      end
      alu_op == OP_AND:  res = acc_q & br_data;
      alu_op == OP_OR:   res = acc_q | br_data;
      alu_op == OP_NOT:  res = ~acc_q;
      alu_op == OP_SHR: begin
        res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        ovf = acc_q[0];
      end
      alu_op == OP_SHL: begin
        res = {acc_q[WIDTH-2:0], 1'b0};
        ovf = acc_q[WIDTH-1];
      end
      alu_op == OP_LOAD: res = br_data;
      default: upd = 1'b0;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    mr_d   = mr_q;
    zf_d   = zf_q;
    nf_d   = nf_q;
    of_d   = of_q;
    done_d = 1'b0;
    if (acc_clear) begin
      acc_d = '0;
      mr_d  = '0;
      zf_d  = 1'b0;
      nf_d  = 1'b0;
      of_d  = 1'b0;
    end else if (mul_done) begin
      acc_d  = prod[WIDTH-1:0];
      mr_d   = prod[2*WIDTH-1:WIDTH];
      zf_d   = (prod == '0);
      nf_d   = prod[2*WIDTH-1];
      of_d   = (prod[2*WIDTH-1:WIDTH]
               != {WIDTH{prod[WIDTH-1]}});
      done_d = 1'b1;
    end else if (op_go) begin
      done_d = 1'b1;
      if (upd) begin
        acc_d = res;
        zf_d  = (res == '0);
        nf_d  = res[WIDTH-1];
        of_d  = ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mr_q   <= '0;
      zf_q   <= 1'b0;
      nf_q   <= 1'b0;
      of_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mr_q   <= mr_d;
      zf_q   <= zf_d;
      nf_q   <= nf_d;
      of_q   <= of_d;
      done_q <= done_d;
    end
  end

  assign acc_data = acc_q;
  assign mr_data  = mr_q;
  assign busy     = mul_busy;
  assign done     = done_q;
  assign zf       = zf_q;
  assign nf       = nf_q;
  assign of       = of_q;

endmodule

// File: tb/tb_acc_alu.sv
// Directed testbench for acc_alu.
// Hand-computed vectors, inline checks, one summary line.
module tb_acc_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] br_data;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic        acc_clear;
  logic [15:0] acc_data;
  logic [15:0] mr_data;
  logic        busy;
  logic        done;
  logic        zf;
  logic        nf;
  logic        of;

  int checks = 0;
  int errors = 0;

  acc_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .br_data   (br_data),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .acc_clear (acc_clear),
    .acc_data  (acc_data),
    .mr_data   (mr_data),
    .busy      (busy),
    .done      (done),
    .zf        (zf),
    .nf        (nf),
    .of        (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start; returns #1 after the sampling edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] br);
    alu_op    = op;
    br_data   = br;
    alu_start = 1'b1;
    @(posedge clk);
    #1;
    alu_start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({acc_data, mr_data} !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got %h exp 0", {acc_data, mr_data});
    end
    checks++;
    if ({busy, done, zf, nf, of} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000", {busy, done, zf, nf, of});
    end
  endtask

  task automatic test_add_sub;
    issue(4'd8, 16'h7FFF);
    issue(4'd0, 16'h0001);
    checks++;
    if ({acc_data, of, nf, zf, done} !== {16'h8000, 4'b1101}) begin
      errors++;
      $display("FAIL add_ovf got %h %b%b%b%b exp 8000 1101",
               acc_data, of, nf, zf, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got %b exp 0", done);
    end
    issue(4'd8, 16'h0005);
    issue(4'd1, 16'h0005);
    checks++;
    if ({acc_data, of, nf, zf} !== {16'h0000, 3'b001}) begin
      errors++;
      $display("FAIL sub_zero got %h %b%b%b exp 0000 001",
               acc_data, of, nf, zf);
    end
  endtask

  task automatic test_logic_shift;
    issue(4'd8, 16'h0F0F);
    issue(4'd2, 16'h00FF);
    checks++;
    if (acc_data !== 16'h000F) begin
      errors++;
      $display("FAIL and got %h exp 000F", acc_data);
    end
    issue(4'd3, 16'hF000);
    checks++;
    if ({acc_data, nf} !== {16'hF00F, 1'b1}) begin
      errors++;
      $display("FAIL or got %h %b exp F00F 1", acc_data, nf);
    end
    issue(4'd4, 16'h0000);
    checks++;
    if ({acc_data, nf, of} !== {16'h0FF0, 2'b00}) begin
      errors++;
      $display("FAIL not got %h %b%b exp 0FF0 00", acc_data, nf, of);
    end
    issue(4'd8, 16'h8003);
    issue(4'd5, 16'h0000);
    checks++;
    if ({acc_data, of, nf} !== {16'hC001, 2'b11}) begin
      errors++;
      $display("FAIL shr got %h %b%b exp C001 11", acc_data, of, nf);
    end
  endtask

  task automatic test_mpy_signed;
    int n;
    issue(4'd8, 16'hFFFD);
    issue(4'd7, 16'h0007);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) br_data = 16'h1234;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL mpy_latency got %0d exp 16", n);
    end
    checks++;
    if ({mr_data, acc_data} !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mpy_prod got %h exp FFFFFFEB", {mr_data, acc_data});
    end
    checks++;
    if ({done, nf, of, zf} !== 4'b1100) begin
      errors++;
      $display("FAIL mpy_flags got %b exp 1100", {done, nf, of, zf});
    end
  endtask

  task automatic test_mpy_overflow;
    int n;
    issue(4'd8, 16'h8000);
    issue(4'd7, 16'h8000);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if ({mr_data, acc_data} !== 32'h4000_0000) begin
      errors++;
      $display("FAIL mpy_min got %h exp 40000000", {mr_data, acc_data});
    end
    checks++;
    if ({of, zf, nf, done} !== 4'b1001) begin
      errors++;
      $display("FAIL mpy_min_flags got %b exp 1001", {of, zf, nf, done});
    end
  endtask

  task automatic test_busy_start_illegal;
    int dones;
    issue(4'd8, 16'h0003);
    issue(4'd7, 16'h0002);
    dones = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 5) begin
        alu_op    = 4'd0;
        br_data   = 16'd100;
        alu_start = 1'b1;
      end else begin
        alu_start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    alu_start = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_start_dones got %0d exp 1", dones);
    end
    checks++;
    if ({mr_data, acc_data} !== 32'h0000_0006) begin
      errors++;
      $display("FAIL busy_start_prod got %h exp 00000006",
               {mr_data, acc_data});
    end
    issue(4'd12, 16'hABCD);
    checks++;
    if ({done, acc_data, zf, nf, of} !== {1'b1, 16'h0006, 3'b000}) begin
      errors++;
      $display("FAIL illegal_op got %b %h %b exp 1 0006 000",
               done, acc_data, {zf, nf, of});
    end
  endtask

  task automatic test_clear;
    int dones;
    issue(4'd8, 16'h7FFF);
    issue(4'd7, 16'h0100);
    while (busy === 1'b1) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({mr_data, acc_data, of} !== {32'h007F_FF00, 1'b1}) begin
      errors++;
      $display("FAIL pre_clear got %h %b exp 007FFF00 1",
               {mr_data, acc_data}, of);
    end
    issue(4'd8, 16'h1234);
    issue(4'd7, 16'h0005);
    repeat (7) begin
      @(posedge clk); #1;
    end
    acc_clear = 1'b1;
    issue(4'd8, 16'h7777);
    acc_clear = 1'b0;
    checks++;
    if ({acc_data, mr_data, busy, done} !== {32'h0, 2'b00}) begin
      errors++;
      $display("FAIL clear got %h %b%b exp 0 00",
               {acc_data, mr_data}, busy, done);
    end
    checks++;
    if ({zf, nf, of} !== 3'b000) begin
      errors++;
      $display("FAIL clear_flags got %b exp 000", {zf, nf, of});
    end
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL clear_no_done got %0d exp 0", dones);
    end
    issue(4'd8, 16'h8001);
    issue(4'd6, 16'h0000);
    checks++;
    if ({acc_data, of, nf} !== {16'h0002, 2'b10}) begin
      errors++;
      $display("FAIL shl got %h %b%b exp 0002 10", acc_data, of, nf);
    end
  endtask

  task automatic test_reset_mid_mpy;
    issue(4'd8, 16'h0100);
    issue(4'd7, 16'h0100);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc_data, mr_data, busy, done, zf, nf, of} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid got %h exp 0",
               {acc_data, mr_data, busy, done, zf, nf, of});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'd8, 16'h0005);
    checks++;
    if ({done, acc_data} !== {1'b1, 16'h0005}) begin
      errors++;
      $display("FAIL post_reset_load got %b %h exp 1 0005",
               done, acc_data);
    end
    issue(4'd0, 16'h0003);
    checks++;
    if ({done, acc_data, mr_data} !== {1'b1, 16'h0008, 16'h0}) begin
      errors++;
      $display("FAIL post_reset_add got %b %h %h exp 1 0008 0000",
               done, acc_data, mr_data);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    br_data   = '0;
    alu_start = 1'b0;
    alu_op    = '0;
    acc_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_sub;
    test_logic_shift;
    test_mpy_signed;
    test_mpy_overflow;
    test_busy_start_illegal;
    test_clear;
    test_reset_mid_mpy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
